mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory port between I-cache refill (fetch side) and D-cache writeback/refill (memory side).
- Sequences line-sized bursts and returns refill words to the cache that owns the burst.
- Generates the f_arrival / m_arrival completion pulses that clear the I-miss and D-miss stalls in the hazard unit.
- Sits between the two caches and the bus interface. There is one outstanding burst at a time.

Parameters:
- LINE_WORDS, 4, words per cache line and beats per burst (power of 2, >=2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_req  in  1  I-cache miss; held high until i_arrival
- i_addr  in  AW  I miss address; stable while i_req
- i_rdata  out  DW  refill word (mem_rdata pass-through)
- i_rvalid  out  1  refill word valid for I side
- i_idx  out  log2(LINE_WORDS)  word index of i_rdata within line
- i_arrival  out  1  one-cycle pulse with last I refill word
- d_req  in  1  D-cache miss; held high until d_arrival
- d_addr  in  AW  D miss address; stable while d_req
- d_wb  in  1  victim dirty; sampled at grant
- d_wb_addr  in  AW  victim line address
- d_wdata  in  DW  current writeback word
- d_wpop  out  1  writeback word consumed; D cache advances d_wdata
- d_rdata  out  DW  refill word
- d_rvalid  out  1  refill word valid for D side
- d_idx  out  log2(LINE_WORDS)  word index of d_rdata
- d_arrival  out  1  one-cycle pulse with last D refill word
- mem_req  out  1  burst command valid
- mem_we  out  1  1 = write burst, 0 = read burst
- mem_addr  out  AW  line-aligned burst address
- mem_gnt  in  1  command accepted this cycle
- mem_wdata  out  DW  write beat data (= d_wdata)
- mem_wready  in  1  write beat accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DW  read beat data

Behaviour:
- States: IDLE, I_CMD, I_RD, D_WCMD, D_WR, D_RCMD, D_RD. There is a beat counter cnt (log2(LINE_WORDS) bits) and a fairness flag last_d.
- Reset, synchronous on rstn=0:
  - state=IDLE, cnt=0, last_d=0.
  - All outputs 0: mem_req, mem_we, i_rvalid, d_rvalid, i_arrival, d_arrival, d_wpop. Data/idx outputs are don't-care.
- Reset mid-burst aborts the burst immediately. The memory side is reset by the same rstn.
- IDLE arbitration, registered. The command appears the cycle after the request is seen.
  - Only i_req: go to I_CMD, last_d<=0.
  - Only d_req: go to D_WCMD if d_wb else D_RCMD, last_d<=1.
  - Both: grant I if last_d=1, else D. This alternates strictly under contention. After reset D wins the first tie.
- I_CMD:
  - mem_req=1, mem_we=0, mem_addr=i_addr with low log2(LINE_WORDS*DW/8) bits zeroed.
  - On mem_gnt go to I_RD, cnt=0.
- I_RD:
  - On each mem_rvalid: i_rvalid=1, i_rdata=mem_rdata, i_idx=cnt, cnt++.
  - On the beat with cnt=LINE_WORDS-1, i_arrival=1 (same cycle) and go to IDLE.
- D_WCMD: mem_req=1, mem_we=1, mem_addr=aligned d_wb_addr. On mem_gnt go to D_WR, cnt=0.
- D_WR:
  - mem_wdata=d_wdata; d_wpop=mem_wready; cnt++ per accepted beat.
  - After the last accepted beat go directly to D_RCMD. The bus is not released between writeback and refill.
- D_RCMD / D_RD: same as I_CMD / I_RD, using d_addr, d_rvalid, d_idx, d_arrival.
- mem_req is state-decoded. It stays high through wait cycles until mem_gnt.
- mem_rvalid outside a *_RD state is ignored. mem_wready outside D_WR is ignored.
- Requester dropping req mid-burst: the burst still completes and rvalid/arrival are still driven. Pipeline flush does not abort refills.
- One idle turnaround cycle after every arrival. A req already pending at the arrival cycle is granted in the following IDLE cycle.
- Arrival pulses are exactly one cycle and never concurrent (i_arrival & d_arrival is always 0).
- cnt wraps naturally at LINE_WORDS. No other arithmetic.

Decomposition:
- Shared package holds:
  - state encoding localparams (3-bit)
  - LINE_WORDS / offset-width derived constants
  - the line-align mask function
- One natural sub-module: burst_cnt (beat counter with clear, enable and last flag), instantiated once.
- FSM and arbitration stay in mem_arbiter.

Test Plan:
- I-only miss at 0x1000_0014, mem_gnt after 2 wait cycles, 4 rvalid beats 0xA0..0xA3 -> mem_addr=0x1000_0010, mem_we=0; i_idx 0..3; i_arrival only with 0xA3; back to IDLE next cycle.
- D miss, d_wb=1, d_wb_addr=0x2000_0040, d_addr=0x3000_0008, mem_wready toggling -> write burst at 0x2000_0040 with exactly 4 d_wpop pulses; then read command at 0x3000_0000 without an IDLE gap; d_arrival on 4th beat.
- i_req and d_req rise in the same cycle after reset, both held -> D served first; I granted in the IDLE cycle after d_arrival. Repeat with both re-asserted -> strict alternation I, D, I.
- d_req rises during an I burst -> no mem_req for D until i_arrival+1; no D rvalid during the I burst.
- rstn=0 during 2nd beat of D_RD -> next cycle all outputs 0, state IDLE; fresh i_req after reset is granted normally.
- Stray mem_rvalid in IDLE and mem_wready in I_RD -> no rvalid/arrival/wpop outputs; cnt unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : state encoding and line-geometry helpers for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_I_CMD  = 3'd1;
    localparam state_t S_I_RD   = 3'd2;
    localparam state_t S_D_WCMD = 3'd3;
    localparam state_t S_D_WR   = 3'd4;
    localparam state_t S_D_RCMD = 3'd5;
    localparam state_t S_D_RD   = 3'd6;

    // Byte-offset bits covered by one cache line.
    function automatic int line_off_bits(input int line_words, input int dw);
        return $clog2(line_words * dw / 8);
    endfunction

    // Mask that clears the byte offset within a line; caller truncates to AW.
    function automatic logic [63:0] line_align_mask(input int off_w);
        logic [63:0] m;
        m = '1;
        m = m << off_w;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_burst_cnt.sv
// ============================================================================
// mem_arbiter_burst_cnt : beat counter with clear, enable and last-beat flag
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_burst_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wraps naturally at 2**W, so a finished burst leaves the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == {W{1'b1}});

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one burst memory port between I-cache refill and
//               D-cache writeback/refill, one outstanding burst at a time
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                          clk,
    input  logic                          rstn,

    input  logic                          i_req,
    input  logic [AW-1:0]                 i_addr,
    output logic [DW-1:0]                 i_rdata,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] i_idx,
    output logic                          i_arrival,

    input  logic                          d_req,
    input  logic [AW-1:0]                 d_addr,
    input  logic                          d_wb,
    input  logic [AW-1:0]                 d_wb_addr,
    input  logic [DW-1:0]                 d_wdata,
    output logic                          d_wpop,
    output logic [DW-1:0]                 d_rdata,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] d_idx,
    output logic                          d_arrival,

    output logic                          mem_req,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    input  logic                          mem_gnt,
    output logic [DW-1:0]                 mem_wdata,
    input  logic                          mem_wready,
    input  logic                          mem_rvalid,
    input  logic [DW-1:0]                 mem_rdata
);

    localparam int          IDX_W      = $clog2(LINE_WORDS);
    localparam int          OFF_W      = line_off_bits(LINE_WORDS, DW);
    localparam logic [AW-1:0] ALIGN_MASK = AW'(line_align_mask(OFF_W));

    state_t             state_q;
    state_t             state_d;
    logic               last_d_q;
    logic               last_d_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_last;
    logic [IDX_W-1:0]   cnt;

    logic               in_cmd;
    logic               in_i_rd;
    logic               in_d_rd;
    logic               in_d_wr;

    assign in_cmd  = (state_q == S_I_CMD) || (state_q == S_D_WCMD) || (state_q == S_D_RCMD);
    assign in_i_rd = (state_q == S_I_RD);
    assign in_d_rd = (state_q == S_D_RD);
    assign in_d_wr = (state_q == S_D_WR);

    // Beats only count in the state that owns them; stray strobes are dropped.
    assign cnt_clr = in_cmd;
    assign cnt_en  = ((in_i_rd || in_d_rd) && mem_rvalid) || (in_d_wr && mem_wready);

    mem_arbiter_burst_cnt #(
        .W (IDX_W)
    ) u_burst_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Under contention the side not served last wins; D wins the first tie.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            S_IDLE: begin
                if (i_req && (!d_req || last_d_q)) begin
                    state_d  = S_I_CMD;
                    last_d_d = 1'b0;
                end else if (d_req) begin
                    state_d  = d_wb ? S_D_WCMD : S_D_RCMD;
                    last_d_d = 1'b1;
                end
            end
            S_I_CMD: begin
                if (mem_gnt) state_d = S_I_RD;
            end
            S_I_RD: begin
                if (mem_rvalid && cnt_last) state_d = S_IDLE;
            end
            S_D_WCMD: begin
                if (mem_gnt) state_d = S_D_WR;
            end
            S_D_WR: begin
                // Refill follows the writeback without giving up the bus.
                if (mem_wready && cnt_last) state_d = S_D_RCMD;
            end
            S_D_RCMD: begin
                if (mem_gnt) state_d = S_D_RD;
            end
            S_D_RD: begin
                if (mem_rvalid && cnt_last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_I_CMD:  mem_addr = i_addr    & ALIGN_MASK;
            S_D_WCMD: mem_addr = d_wb_addr & ALIGN_MASK;
            S_D_RCMD: mem_addr = d_addr    & ALIGN_MASK;
            default:  mem_addr = '0;
        endcase
    end

    // Strobes are gated by rstn so a reset cycle never leaks a beat or pulse.
    assign mem_req   = rstn && in_cmd;
    assign mem_we    = rstn && (state_q == S_D_WCMD);
    assign mem_wdata = d_wdata;

    assign d_wpop    = rstn && in_d_wr && mem_wready;

    assign i_rvalid  = rstn && in_i_rd && mem_rvalid;
    assign i_rdata   = mem_rdata;
    assign i_idx     = cnt;
    assign i_arrival = i_rvalid && cnt_last;

    assign d_rvalid  = rstn && in_d_rd && mem_rvalid;
    assign d_rdata   = mem_rdata;
    assign d_idx     = cnt;
    assign d_arrival = d_rvalid && cnt_last;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int LW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] K_CMD  = 2'd0;
    localparam logic [1:0] K_IRD  = 2'd1;
    localparam logic [1:0] K_DRD  = 2'd2;
    localparam logic [1:0] K_WPOP = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        flag;   // mem_we for commands, arrival for beats
        logic [1:0]  idx;
        logic [31:0] val;    // address for commands, data otherwise
    } ev_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_rvalid;
    logic [1:0]    i_idx;
    logic          i_arrival;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_wb = 1'b0;
    logic [AW-1:0] d_wb_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_wpop;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic [1:0]    d_idx;
    logic          d_arrival;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    logic [31:0] wb_words [LW] = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};

    always #5 clk = ~clk;

    mem_arbiter #(
        .LINE_WORDS (LW),
        .AW         (AW),
        .DW         (DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_rvalid   (i_rvalid),
        .i_idx      (i_idx),
        .i_arrival  (i_arrival),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_wb       (d_wb),
        .d_wb_addr  (d_wb_addr),
        .d_wdata    (d_wdata),
        .d_wpop     (d_wpop),
        .d_rdata    (d_rdata),
        .d_rvalid   (d_rvalid),
        .d_idx      (d_idx),
        .d_arrival  (d_arrival),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mon_event(input string name, input ev_t act);
        ev_t exp;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected actual=%0h expected=none", name, act);
        end else begin
            exp = expq.pop_front();
            check(name, 64'(act), 64'(exp));
        end
    endtask

    // Monitor: every presented output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_req && mem_gnt)
                mon_event("cmd", ev_t'{K_CMD, mem_we, 2'd0, mem_addr});
            if (i_rvalid)
                mon_event("i_beat", ev_t'{K_IRD, i_arrival, i_idx, i_rdata});
            if (d_rvalid)
                mon_event("d_beat", ev_t'{K_DRD, d_arrival, d_idx, d_rdata});
            if (d_wpop)
                mon_event("wpop", ev_t'{K_WPOP, 1'b0, 2'd0, mem_wdata});
            if (i_arrival || d_arrival)
                check("arrival_excl",
                      64'({i_arrival && d_arrival, i_arrival && !i_rvalid, d_arrival && !d_rvalid}),
                      64'(0));
        end
    end

    task automatic push(input logic [1:0] k, input logic f, input logic [1:0] idx, input logic [31:0] v);
        expq.push_back(ev_t'{k, f, idx, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {mem_req, mem_we, i_rvalid, d_rvalid, i_arrival, d_arrival, d_wpop};
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 64'(mem_req), 64'(1));
    endtask

    task automatic serve_cmd(input int waits);
        wait_req();
        for (int w = 0; w < waits; w++) begin
            tick();
            check("req_held", 64'(mem_req), 64'(1));
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    // Four read beats with one idle gap after beat 1.
    task automatic serve_rd(input logic [31:0] base, input logic stray_wr, input logic raise_d);
        for (int k = 0; k < LW; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(k);
            mem_wready = stray_wr;
            tick();
            if (k == 1) begin
                mem_rvalid = 1'b0;
                tick();
                if (raise_d) d_req = 1'b1;
            end
        end
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
    endtask

    task automatic read_burst(input logic dside, input logic [31:0] exp_addr, input logic [31:0] base,
                              input int waits, input logic stray_wr, input logic raise_d);
        push(K_CMD, 1'b0, 2'd0, exp_addr);
        for (int k = 0; k < LW; k++)
            push(dside ? K_DRD : K_IRD, (k == LW - 1), 2'(k), base + 32'(k));
        serve_cmd(waits);
        serve_rd(base, stray_wr, raise_d);
    endtask

    // Requester still pending at arrival: one idle cycle, then its command.
    task automatic turnaround();
        check("turn_idle", 64'(mem_req), 64'(0));
        tick();
        check("turn_cmd", 64'(mem_req), 64'(1));
    endtask

    initial begin
        int k;
        int cyc;

        // Reset state
        tick();
        check("rst_outs", 64'(outs()), 64'(0));
        tick();
        rstn = 1'b1;
        tick();
        check("idle_outs", 64'(outs()), 64'(0));

        // I-only miss, two wait cycles before grant
        i_addr = 32'h1000_0014;
        i_req  = 1'b1;
        read_burst(1'b0, 32'h1000_0010, 32'h0000_00A0, 2, 1'b0, 1'b0);
        i_req = 1'b0;
        check("i_back_idle", 64'(outs()), 64'(0));
        tick();
        check("i_stay_idle", 64'(mem_req), 64'(0));

        // D miss with dirty victim: writeback then refill, no idle gap
        d_addr    = 32'h3000_0008;
        d_wb_addr = 32'h2000_0040;
        d_wb      = 1'b1;
        d_wdata   = wb_words[0];
        d_req     = 1'b1;
        push(K_CMD, 1'b1, 2'd0, 32'h2000_0040);
        for (int j = 0; j < LW; j++) push(K_WPOP, 1'b0, 2'd0, wb_words[j]);
        push(K_CMD, 1'b0, 2'd0, 32'h3000_0000);
        for (int j = 0; j < LW; j++) push(K_DRD, (j == LW - 1), 2'(j), 32'h0000_00C0 + 32'(j));
        serve_cmd(1);
        k   = 0;
        cyc = 0;
        while (k < LW && cyc < 40) begin
            mem_wready = cyc[0];
            tick();
            if (mem_wready) begin
                k++;
                d_wdata = wb_words[k % LW];
            end
            cyc++;
        end
        mem_wready = 1'b0;
        check("wr_beats", 64'(k), 64'(LW));
        check("wr_to_rcmd", 64'({mem_req, mem_we}), 64'(2'b10));
        serve_cmd(0);
        serve_rd(32'h0000_00C0, 1'b0, 1'b0);
        d_req = 1'b0;
        d_wb  = 1'b0;
        tick();

        // Simultaneous requests after reset: D, I, D, I
        rstn = 1'b0;
        tick();
        rstn   = 1'b1;
        i_addr = 32'h1000_0104;
        d_addr = 32'h3000_0118;
        i_req  = 1'b1;
        d_req  = 1'b1;
        read_burst(1'b1, 32'h3000_0110, 32'h0000_00D0, 0, 1'b0, 1'b0);
        turnaround();
        read_burst(1'b0, 32'h1000_0100, 32'h0000_00B0, 1, 1'b0, 1'b0);
        turnaround();
        read_burst(1'b1, 32'h3000_0110, 32'h0000_00E0, 0, 1'b0, 1'b0);
        turnaround();
        read_burst(1'b0, 32'h1000_0100, 32'h0000_00F0, 0, 1'b0, 1'b0);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();

        // d_req rising during an I burst waits for arrival + 1
        i_addr = 32'h1000_0200;
        d_addr = 32'h5000_0024;
        i_req  = 1'b1;
        read_burst(1'b0, 32'h1000_0200, 32'h0000_0070, 1, 1'b0, 1'b1);
        i_req = 1'b0;
        turnaround();
        read_burst(1'b1, 32'h5000_0020, 32'h0000_0080, 0, 1'b0, 1'b0);
        d_req = 1'b0;
        tick();

        // Stray strobes in IDLE and mem_wready during I_RD
        mem_rvalid = 1'b1;
        mem_wready = 1'b1;
        tick();
        check("stray_idle", 64'(outs()), 64'(0));
        tick();
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
        i_addr = 32'h1000_0300;
        i_req  = 1'b1;
        read_burst(1'b0, 32'h1000_0300, 32'h0000_0060, 0, 1'b1, 1'b0);
        i_req = 1'b0;
        tick();

        // Reset on the second beat of a D refill
        d_addr = 32'h3000_0208;
        d_req  = 1'b1;
        push(K_CMD, 1'b0, 2'd0, 32'h3000_0200);
        push(K_DRD, 1'b0, 2'd0, 32'h0000_0090);
        serve_cmd(0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0090;
        tick();
        mem_rdata = 32'h0000_0091;
        rstn      = 1'b0;
        d_req     = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_abort_outs", 64'(outs()), 64'(0));
        mem_rvalid = 1'b0;
        i_addr = 32'h4000_003C;
        i_req  = 1'b1;
        read_burst(1'b0, 32'h4000_0030, 32'h0000_0040, 0, 1'b0, 1'b0);
        i_req = 1'b0;
        tick();
        tick();

        check("queue_empty", 64'(expq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
